riscv_data_bus: RTL and testbench
=================================

Name: riscv_data_bus

Overview:
Parametrised data-side interconnect between riscv_lsu and N memory-mapped slaves, such as ext_mem, a second RAM, or peripherals.
- Decodes the upper address byte to select one slave and forwards the LSU request with a slave-relative offset.
- Waits for that slave's ready signal and returns the read data.
- Completes with a bus error if the address is unmapped or the slave does not respond within a timeout.
- Replaces the direct riscv_lsu-to-ext_mem connection in riscv_unit.

Parameters:
N_SLAVES, 4, number of slave channels (1..256).
TIMEOUT, 16, maximum ACCESS cycles without slave ready before an error (≥2).
OFFSET_W, 24, width of the slave-relative offset; bits [31:OFFSET_W] select the slave.
ERR_DATA, 32'hDEAD_BEEF, read data returned on an error completion.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
mem_req_i  in  1  request from LSU, held until mem_ready_o
mem_we_i  in  1  write enable
mem_be_i  in  4  byte enables
mem_addr_i  in  32  byte address
mem_wd_i  in  32  write data
mem_rd_o  out  32  read data, valid with mem_ready_o
mem_ready_o  out  1  one-cycle completion pulse
slv_req_o  out  N_SLAVES  one-hot slave request
slv_we_o  out  1  registered write enable
slv_be_o  out  4  registered byte enables
slv_addr_o  out  32  registered offset, zero-extended from mem_addr_i[OFFSET_W-1:0]
slv_wd_o  out  32  registered write data
slv_rd_i  in  N_SLAVES×32  per-slave read data
slv_ready_i  in  N_SLAVES  per-slave ready
err_o  out  1  one-cycle pulse, coincident with an error completion
err_addr_o  out  32  full address of the last faulting access (sticky)

Behaviour:
- Clock and reset: single clock clk_i; reset rst_i is synchronous, active-high.
- Reset values: state=IDLE; mem_ready_o=0; mem_rd_o=0; slv_req_o=0; slv_we_o=0; slv_be_o=0; slv_addr_o=0; slv_wd_o=0; err_o=0; err_addr_o=0; timeout counter=0.
- Slave decode: idx = mem_addr_i[31:OFFSET_W]. An address is unmapped if idx ≥ N_SLAVES.
- IDLE:
  - mem_req_i=1 and mapped: latch we/be/offset/wd and idx, counter←0, go ACCESS.
  - mem_req_i=1 and unmapped: go ERR.
  - Otherwise stay in IDLE.
- ACCESS:
  - slv_req_o[idx]=1, all other bits 0; registered request fields are stable.
  - slv_ready_i[idx]=1: capture slv_rd_i[idx] into mem_rd_o, go DONE.
  - Ready from non-selected slaves is ignored.
  - Else if counter==TIMEOUT-1: go ERR.
  - Else counter+1.
- DONE (1 cycle): mem_ready_o=1, slv_req_o=0, then go IDLE.
- ERR (1 cycle): mem_ready_o=1, mem_rd_o=ERR_DATA, err_o=1, err_addr_o←original address, slv_req_o=0, then go IDLE.
- mem_req_i is ignored in DONE and ERR. The LSU drops req after ready, so the same request is never accepted twice.
- Latency: accept-to-ready is minimum 2 cycles (IDLE→ACCESS with immediate ready→DONE). Unmapped completes in 1 cycle after accept. Timeout completes TIMEOUT+1 cycles after accept.
- Back-to-back: a new request may be accepted in the IDLE cycle immediately after DONE/ERR.
- Writes: mem_rd_o is still updated from the slave on DONE; the LSU ignores it.
- Reset mid-ACCESS: slv_req_o drops to 0 the next cycle, with no completion pulse; any late slave ready is ignored.
- mem_addr_i changing during ACCESS has no effect, because fields are registered.

Decomposition:
- Package riscv_bus_pkg holds:
  - the state enum bus_state_t {IDLE, ACCESS, DONE, ERR};
  - the constant DEFAULT_ERR_DATA;
  - a function slv_idx_w(N) = $clog2(N) with minimum 1.
- Sub-module riscv_bus_decoder (combinational) maps address to {idx, hit}, is parametrised by N_SLAVES and OFFSET_W, and is reused by the future instruction-side bus.
- FSM, timeout counter and response register live in the top.

Test Plan:
- Read hit: N_SLAVES=4; slave1 at addr 32'h0100_0010 with ready after 3 cycles and rd 32'h1234_5678 → slv_req_o=4'b0010, slv_addr_o=32'h10; mem_ready_o pulses once, mem_rd_o=32'h1234_5678, err_o=0.
- Write: addr 32'h0000_0004, be=4'b0011, wd=32'hA5A5_0000, slave0 with immediate ready → slv_we_o=1, slv_be_o=4'b0011, slv_wd_o=32'hA5A5_0000; completion 2 cycles after accept.
- Unmapped: addr 32'h0700_0000 → no slv_req_o; the next cycle gives mem_ready_o=1, mem_rd_o=32'hDEAD_BEEF, err_o=1, err_addr_o=32'h0700_0000.
- Timeout: TIMEOUT=16, slave2 never ready → slv_req_o[2] held 16 cycles, then an ERR completion; err_addr_o updated.
- Reset mid-ACCESS plus stray ready: rst_i pulsed in the 2nd ACCESS cycle → next cycle all outputs at reset values; slave ready asserted afterwards produces no mem_ready_o.
- Back-to-back: two reads to slaves 0 then 3, with req reasserted in the IDLE cycle after DONE → both complete in order with correct data; at most one slv_req_o bit high in any cycle.

Source files
------------

// File: rtl/riscv_bus_pkg.sv
// Shared types and helpers for the riscv data/instruction-side slave interconnects.
package riscv_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2,
    ERR    = 2'd3
  } bus_state_t;

  localparam logic [31:0] DEFAULT_ERR_DATA = 32'hDEAD_BEEF;

  // Slave index width; a single slave still needs one bit to index with.
  function automatic int slv_idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/riscv_bus_decoder.sv
// Address decoder: upper address bits select a slave; hit is low for unmapped indices.
// Purely combinational, no state and no flow control.
module riscv_bus_decoder
  import riscv_bus_pkg::*;
#(
  parameter int N_SLAVES = 4,
  parameter int OFFSET_W = 24,
  parameter int IDX_W    = slv_idx_w(N_SLAVES)
) (
  input  logic [31:0]      i_addr,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_hit
);

  localparam int          SEL_W  = 32 - OFFSET_W;
  localparam logic [31:0] N_SLV  = 32'(N_SLAVES);

  logic [SEL_W-1:0] w_sel;

  assign w_sel = i_addr[31:OFFSET_W];
  assign o_idx = IDX_W'(w_sel);
  assign o_hit = (32'(w_sel) < N_SLV);

endmodule

// File: rtl/riscv_data_bus.sv
// LSU-to-N-slave data interconnect: decode, registered request, ready wait, timeout/unmapped error.
// Accept-to-ready >= 2 cycles (1 for unmapped, TIMEOUT+1 on timeout); LSU holds req until ready.
module riscv_data_bus
  import riscv_bus_pkg::*;
#(
  parameter int          N_SLAVES = 4,
  parameter int          TIMEOUT  = 16,
  parameter int          OFFSET_W = 24,
  parameter logic [31:0] ERR_DATA = DEFAULT_ERR_DATA
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     mem_req_i,
  input  logic                     mem_we_i,
  input  logic [3:0]               mem_be_i,
  input  logic [31:0]              mem_addr_i,
  input  logic [31:0]              mem_wd_i,
  output logic [31:0]              mem_rd_o,
  output logic                     mem_ready_o,
  output logic [N_SLAVES-1:0]      slv_req_o,
  output logic                     slv_we_o,
  output logic [3:0]               slv_be_o,
  output logic [31:0]              slv_addr_o,
  output logic [31:0]              slv_wd_o,
  input  logic [N_SLAVES-1:0][31:0] slv_rd_i,
  input  logic [N_SLAVES-1:0]      slv_ready_i,
  output logic                     err_o,
  output logic [31:0]              err_addr_o
);

  localparam int             IDX_W   = slv_idx_w(N_SLAVES);
  localparam int             CNT_W   = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  bus_state_t          r_state;
  bus_state_t          w_next;
  logic [IDX_W-1:0]    r_idx;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_we;
  logic [3:0]          r_be;
  logic [31:0]         r_offs;
  logic [31:0]         r_wd;
  logic [31:0]         r_full_addr;
  logic [31:0]         r_rd;
  logic [31:0]         r_err_addr;

  logic [IDX_W-1:0]    w_idx;
  logic                w_hit;
  logic                w_sel_rdy;
  logic [31:0]         w_sel_rd;
  logic [N_SLAVES-1:0] w_req;

  riscv_bus_decoder #(
    .N_SLAVES (N_SLAVES),
    .OFFSET_W (OFFSET_W),
    .IDX_W    (IDX_W)
  ) u_dec (
    .i_addr (mem_addr_i),
    .o_idx  (w_idx),
    .o_hit  (w_hit)
  );

  // Only the latched slave is ever looked at, so stray ready from others is ignored.
  assign w_sel_rdy = slv_ready_i[r_idx];
  assign w_sel_rd  = slv_rd_i[r_idx];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (mem_req_i) begin
          w_next = w_hit ? ACCESS : ERR;
        end
      end
      ACCESS: begin
        if (w_sel_rdy) begin
          w_next = DONE;
        end else if (r_cnt == CNT_LAST) begin
          w_next = ERR;
        end
      end
      DONE:    w_next = IDLE;
      ERR:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_idx       <= '0;
      r_cnt       <= '0;
      r_we        <= 1'b0;
      r_be        <= 4'b0;
      r_offs      <= 32'b0;
      r_wd        <= 32'b0;
      r_full_addr <= 32'b0;
      r_rd        <= 32'b0;
      r_err_addr  <= 32'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (mem_req_i) begin
            if (w_hit) begin
              r_idx       <= w_idx;
              r_cnt       <= '0;
              r_we        <= mem_we_i;
              r_be        <= mem_be_i;
              r_offs      <= 32'(mem_addr_i[OFFSET_W-1:0]);
              r_wd        <= mem_wd_i;
              r_full_addr <= mem_addr_i;
            end else begin
              r_rd       <= ERR_DATA;
              r_err_addr <= mem_addr_i;
            end
          end
        end
        ACCESS: begin
          if (w_sel_rdy) begin
            r_rd <= w_sel_rd;
          end else if (r_cnt == CNT_LAST) begin
            r_rd       <= ERR_DATA;
            r_err_addr <= r_full_addr;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_req = '0;
    if (r_state == ACCESS) begin
      w_req[r_idx] = 1'b1;
    end
  end

  assign slv_req_o   = w_req;
  assign slv_we_o    = r_we;
  assign slv_be_o    = r_be;
  assign slv_addr_o  = r_offs;
  assign slv_wd_o    = r_wd;
  assign mem_rd_o    = r_rd;
  assign mem_ready_o = (r_state == DONE) || (r_state == ERR);
  assign err_o       = (r_state == ERR);
  assign err_addr_o  = r_err_addr;

endmodule

// File: tb/tb_riscv_data_bus.sv
// Directed bench for riscv_data_bus: stimulus pushes expected completions, a monitor pops and compares.
module tb_riscv_data_bus;

  logic             clk_i;
  logic             rst_i;
  logic             mem_req_i;
  logic             mem_we_i;
  logic [3:0]       mem_be_i;
  logic [31:0]      mem_addr_i;
  logic [31:0]      mem_wd_i;
  logic [31:0]      mem_rd_o;
  logic             mem_ready_o;
  logic [3:0]       slv_req_o;
  logic             slv_we_o;
  logic [3:0]       slv_be_o;
  logic [31:0]      slv_addr_o;
  logic [31:0]      slv_wd_o;
  logic [3:0][31:0] slv_rd_i;
  logic [3:0]       slv_ready_i;
  logic             err_o;
  logic [31:0]      err_addr_o;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    logic [31:0] ea;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] last_ea;
  int          n_cmp;
  int          n_bad;

  riscv_data_bus dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .mem_req_i   (mem_req_i),
    .mem_we_i    (mem_we_i),
    .mem_be_i    (mem_be_i),
    .mem_addr_i  (mem_addr_i),
    .mem_wd_i    (mem_wd_i),
    .mem_rd_o    (mem_rd_o),
    .mem_ready_o (mem_ready_o),
    .slv_req_o   (slv_req_o),
    .slv_we_o    (slv_we_o),
    .slv_be_o    (slv_be_o),
    .slv_addr_o  (slv_addr_o),
    .slv_wd_o    (slv_wd_o),
    .slv_rd_i    (slv_rd_i),
    .slv_ready_i (slv_ready_i),
    .err_o       (err_o),
    .err_addr_o  (err_addr_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  // Monitor: every completion pulse must match the oldest expected entry.
  initial begin
    forever begin
      @(negedge clk_i);
      if (!rst_i) begin
        chk("req_onehot", 32'($countones(slv_req_o) <= 1), 32'd1);
        if (err_o && !mem_ready_o) begin
          chk("err_without_ready", 32'(err_o), 32'd0);
        end
        if (mem_ready_o) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_ready: got rd=%h err=%b want no completion", mem_rd_o, err_o);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("mem_rd", mem_rd_o, e.rd);
            chk("err_o", 32'(err_o), 32'(e.err));
            chk("err_addr", err_addr_o, e.ea);
          end
        end
      end
    end
  end

  // One LSU transaction. slv<0: unmapped; dly<0: selected slave never ready.
  task automatic access(input string nm, input logic [31:0] addr, input logic we,
                        input logic [3:0] be, input logic [31:0] wd, input int slv,
                        input int dly, input logic [31:0] rdat, input logic [3:0] noise,
                        input logic wiggle, input int exp_lat);
    exp_t e;
    int   lat;
    logic done;
    logic is_err;
    is_err = (slv < 0) || (dly < 0);
    if (is_err) last_ea = addr;
    e.rd  = is_err ? 32'hDEAD_BEEF : rdat;
    e.err = is_err;
    e.ea  = last_ea;
    exp_q.push_back(e);
    mem_req_i  = 1'b1;
    mem_we_i   = we;
    mem_be_i   = be;
    mem_addr_i = addr;
    mem_wd_i   = wd;
    lat  = 0;
    done = 1'b0;
    while (!done && lat < 64) begin
      @(posedge clk_i);
      #1;
      lat++;
      slv_ready_i = 4'b0;
      if (mem_ready_o) begin
        done = 1'b1;
        chk({nm, "_req_in_done"}, 32'(slv_req_o), 32'd0);
      end else if (slv >= 0) begin
        chk({nm, "_slv_req"}, 32'(slv_req_o), 32'(4'b0001 << slv));
        if (lat == 1) begin
          chk({nm, "_slv_addr"}, slv_addr_o, {8'h00, addr[23:0]});
          chk({nm, "_slv_we"}, 32'(slv_we_o), 32'(we));
          chk({nm, "_slv_be"}, 32'(slv_be_o), 32'(be));
          chk({nm, "_slv_wd"}, slv_wd_o, wd);
          if (wiggle) mem_addr_i = 32'h0100_0000;
        end
        slv_ready_i = noise;
        if (dly >= 0 && lat - 1 == dly) begin
          slv_ready_i[slv] = 1'b1;
          slv_rd_i[slv]    = rdat;
        end
      end
    end
    chk({nm, "_completed"}, 32'(done), 32'd1);
    chk({nm, "_latency"}, 32'(lat), 32'(exp_lat));
    mem_req_i   = 1'b0;
    slv_ready_i = 4'b0;
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_ready"},    32'(mem_ready_o), 32'd0);
    chk({nm, "_rd"},       mem_rd_o,         32'd0);
    chk({nm, "_slv_req"},  32'(slv_req_o),   32'd0);
    chk({nm, "_slv_we"},   32'(slv_we_o),    32'd0);
    chk({nm, "_slv_be"},   32'(slv_be_o),    32'd0);
    chk({nm, "_slv_addr"}, slv_addr_o,       32'd0);
    chk({nm, "_slv_wd"},   slv_wd_o,         32'd0);
    chk({nm, "_err"},      32'(err_o),       32'd0);
    chk({nm, "_err_addr"}, err_addr_o,       32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp       = 0;
    n_bad       = 0;
    last_ea     = 32'h0;
    rst_i       = 1'b1;
    mem_req_i   = 1'b0;
    mem_we_i    = 1'b0;
    mem_be_i    = 4'b0;
    mem_addr_i  = 32'h0;
    mem_wd_i    = 32'h0;
    slv_ready_i = 4'b0;
    for (int k = 0; k < 4; k++) slv_rd_i[k] = 32'h5000_0000 + 32'(k);
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    chk_reset_vals("por");

    // name, addr, we, be, wd, slave, ready delay, rdata, noise ready, wiggle, latency
    access("read_hit",  32'h0100_0010, 1'b0, 4'b1111, 32'h0,         1,  3, 32'h1234_5678, 4'b0001, 1'b0, 5);
    access("write",     32'h0000_0004, 1'b1, 4'b0011, 32'hA5A5_0000, 0,  0, 32'h0000_CAFE, 4'b0000, 1'b0, 2);
    access("unmapped",  32'h0700_0000, 1'b0, 4'b1111, 32'h0,        -1,  0, 32'h0,         4'b0000, 1'b0, 1);
    access("unmap_bnd", 32'h04FF_FFFC, 1'b0, 4'b1111, 32'h0,        -1,  0, 32'h0,         4'b0000, 1'b0, 1);
    access("timeout",   32'h0200_0040, 1'b0, 4'b1111, 32'h0,         2, -1, 32'h0,         4'b1000, 1'b1, 17);
    access("after_err", 32'h03FF_FFF0, 1'b0, 4'b1111, 32'h0,         3,  1, 32'h3333_0000, 4'b0000, 1'b0, 3);

    // Reset in the second ACCESS cycle, then a stray ready from the abandoned slave.
    mem_req_i  = 1'b1;
    mem_we_i   = 1'b0;
    mem_be_i   = 4'b1111;
    mem_addr_i = 32'h0200_0000;
    @(posedge clk_i);
    #1;
    chk("rst_mid_req1", 32'(slv_req_o), 32'b0100);
    @(posedge clk_i);
    #1;
    rst_i     = 1'b1;
    mem_req_i = 1'b0;
    @(posedge clk_i);
    #1;
    rst_i   = 1'b0;
    last_ea = 32'h0;
    chk_reset_vals("rst_mid");
    slv_ready_i   = 4'b0100;
    slv_rd_i[2]   = 32'hBAD0_0002;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk_i);
      #1;
      chk("stray_ready", 32'(mem_ready_o), 32'd0);
    end
    slv_ready_i = 4'b0;

    access("b2b_s0", 32'h0000_0100, 1'b0, 4'b1111, 32'h0, 0, 1, 32'h0BAD_F00D, 4'b0000, 1'b0, 3);
    access("b2b_s3", 32'h0300_0008, 1'b0, 4'b1111, 32'h0, 3, 2, 32'h7777_8888, 4'b0000, 1'b0, 4);

    repeat (2) @(posedge clk_i);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
